// File: rtl/uart_word_sequencer.sv
// Sequences one 16-bit word through the UART byte datapath: MS byte then LS byte out, matching bytes back in.
// Optional per-byte timeout enabled by defining SEQ_TIMEOUT_EN.
module uart_word_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  output logic        tx_en,
  input  logic        tx_busy,
  output logic        rx_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_ferror,
  input  logic        rx_perror,
  output logic        ready,
  output logic        done,
  output logic [15:0] rx_word,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_BUSY, WAIT_TXDONE, WAIT_RX, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  ms_hold_q, ms_hold_d;
  logic [15:0] rx_word_q, rx_word_d;
  logic        error_q, error_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_wr_q, tx_wr_d;
  logic        tx_en_q, tx_en_d;
  logic        rx_en_q, rx_en_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic        rx_event;
  logic        capture;
  logic [7:0]  got_byte;
  logic        got_err;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [20:0] CNT_LAST = 21'(TIMEOUT_CYCLES - 1);
  logic [20:0] cnt_q, cnt_d;
  logic        in_wait;
`endif

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch below can leave one unassigned and infer a latch.
    state_d   = state_q;
    sel_d     = sel_q;
    word_d    = word_q;
    ms_hold_d = ms_hold_q;
    rx_word_d = rx_word_q;
    error_d   = error_q;
    tx_data_d = tx_data_q;
    rx_event  = rx_valid | rx_ferror | rx_perror;
    capture   = 1'b0;
    got_byte  = rx_data;
    got_err   = rx_ferror | rx_perror;

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = word;
          sel_d   = 1'b0;
          error_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_TXDONE;
      WAIT_TXDONE: begin
        // A fast loopback can return the byte before we see busy drop; take it here.
        if (rx_event)      capture = 1'b1;
        else if (!tx_busy) state_d = WAIT_RX;
      end
      WAIT_RX:   capture = rx_event;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase

`ifdef SEQ_TIMEOUT_EN
    in_wait = (state_q == WAIT_BUSY) || (state_q == WAIT_TXDONE) || (state_q == WAIT_RX);
    cnt_d   = cnt_q;
    if (state_q == LOAD) cnt_d = '0;
    else if (in_wait)    cnt_d = cnt_q + 21'd1;
    // A lost byte is filled with 8'hBB and the sequence carries on as if it arrived.
    if (in_wait && (cnt_q == CNT_LAST) && !capture) begin
      capture  = 1'b1;
      got_byte = 8'hBB;
      got_err  = 1'b1;
    end
`endif

    if (capture) begin
      error_d = error_q | got_err;
      if (!sel_q) begin
        ms_hold_d = got_byte;
        sel_d     = 1'b1;
        state_d   = LOAD;
      end else begin
        rx_word_d = {ms_hold_q, got_byte};
        state_d   = FINISH;
      end
    end

    // Outputs are registered, so they are decoded from the state being entered.
    tx_wr_d = (state_d == LOAD);
    tx_en_d = (state_d == LOAD) || (state_d == WAIT_BUSY) || (state_d == WAIT_TXDONE);
    rx_en_d = tx_en_d || (state_d == WAIT_RX);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == FINISH);
    if (state_d == LOAD) tx_data_d = sel_d ? word_d[7:0] : word_d[15:8];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      word_q    <= '0;
      ms_hold_q <= '0;
      rx_word_q <= '0;
      error_q   <= 1'b0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      rx_en_q   <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      word_q    <= word_d;
      ms_hold_q <= ms_hold_d;
      rx_word_q <= rx_word_d;
      error_q   <= error_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      tx_en_q   <= tx_en_d;
      rx_en_q   <= rx_en_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign tx_en   = tx_en_q;
  assign rx_en   = rx_en_q;
  assign ready   = ready_q;
  assign done    = done_q;
  assign rx_word = rx_word_q;
  assign error   = error_q;

endmodule

// File: tb/tb_uart_word_sequencer.sv
// Scoreboard bench for uart_word_sequencer: a line model plays transmitter + loopback receiver,
// a monitor checks every tx_wr byte and every done result against queued expectations.
module tb_uart_word_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] word;
  logic [7:0]  tx_data;
  logic        tx_wr, tx_en, tx_busy, rx_en;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferror, rx_perror;
  logic        ready, done, error;
  logic [15:0] rx_word;

  always #5 clk = ~clk;

  uart_word_sequencer #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .word(word),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ferror(rx_ferror), .rx_perror(rx_perror),
    .ready(ready), .done(done), .rx_word(rx_word), .error(error)
  );

  // How the line behaves for one transmitted byte.
  typedef struct {
    logic [7:0] data;
    logic       valid, ferr, perr, silent;
    int         d1, busy_len, d2;
  } byte_plan_t;

  typedef struct {
    logic [15:0] word;
    logic        err;
  } result_t;

  byte_plan_t plan_q[$];
  logic [7:0] tx_exp[$];
  result_t    sb[$];

  int         errors = 0;
  int         checks = 0;
  int         tx_wr_count = 0;
  int         done_count = 0;
  logic [7:0] last_tx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word = {byte back for MS, byte back for LS}; lost bytes read 8'hBB; any
  // framing/parity/loss on either byte makes the error flag set.
  function automatic result_t model(input byte_plan_t p0, input byte_plan_t p1);
    result_t r;
    r.word[15:8] = p0.silent ? 8'hBB : p0.data;
    r.word[7:0]  = p1.silent ? 8'hBB : p1.data;
    r.err = p0.ferr | p0.perr | p0.silent | p1.ferr | p1.perr | p1.silent;
    return r;
  endfunction

  function automatic byte_plan_t clean_plan(input logic [7:0] b);
    byte_plan_t p;
    p.data = b; p.valid = 1'b1; p.ferr = 1'b0; p.perr = 1'b0; p.silent = 1'b0;
    p.d1 = 1; p.busy_len = 3; p.d2 = 1;
    return p;
  endfunction

  function automatic byte_plan_t rand_plan(input logic [7:0] b);
    byte_plan_t p;
    p.data     = b ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    p.ferr     = ($urandom_range(0, 7) == 0);
    p.perr     = ($urandom_range(0, 7) == 0);
    p.valid    = (p.ferr | p.perr) ? 1'($urandom_range(0, 1)) : 1'b1;
    p.silent   = 1'b0;
    p.d1       = $urandom_range(0, 2);
    p.busy_len = $urandom_range(2, 6);
    p.d2       = $urandom_range(0, 3);
    return p;
  endfunction

  task automatic expect_txn(input logic [15:0] w, input byte_plan_t p0, input byte_plan_t p1);
    plan_q.push_back(p0);
    plan_q.push_back(p1);
    tx_exp.push_back(w[15:8]);
    tx_exp.push_back(w[7:0]);
    sb.push_back(model(p0, p1));
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_budget", ready, 1);
  endtask

  // Leaves start low at the negedge following the accepting edge (the LOAD cycle).
  task automatic start_word(input logic [15:0] w);
    wait_ready(500);
    word  = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Transmitter + loopback receiver model.
  initial begin
    byte_plan_t p;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0; rx_data = 8'h00;
    forever begin
      if (tx_wr === 1'b1 && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        repeat (p.d1) @(negedge clk);
        tx_busy = 1'b1;
        repeat (p.busy_len) @(negedge clk);
        tx_busy = 1'b0;
        if (!p.silent) begin
          repeat (p.d2) @(negedge clk);
          rx_data = p.data; rx_valid = p.valid; rx_ferror = p.ferr; rx_perror = p.perr;
          @(negedge clk);
          rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0; rx_data = 8'($urandom);
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes a byte or completes a word.
  initial begin
    result_t e;
    int      pending;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (tx_wr === 1'b1) begin
          tx_wr_count++;
          pending = tx_exp.size();
          check("tx_wr_expected", pending != 0, 1);
          if (pending != 0) check("tx_data", tx_data, tx_exp.pop_front());
          last_tx = tx_data;
        end else if (tx_en === 1'b1) begin
          check("tx_data_stable", tx_data, last_tx);
        end
        if (done === 1'b1) begin
          done_count++;
          pending = sb.size();
          check("done_expected", pending != 0, 1);
          if (pending != 0) begin
            e = sb.pop_front();
            check("rx_word", rx_word, e.word);
            check("error", error, e.err);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          tc0, dc0, n;
    logic [15:0] w;
    byte_plan_t  p0, p1;

    reset = 1'b1; start = 1'b0; word = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready",   ready,   1);
    check("rst_done",    done,    0);
    check("rst_tx_wr",   tx_wr,   0);
    check("rst_tx_en",   tx_en,   0);
    check("rst_rx_en",   rx_en,   0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_word", rx_word, 16'h0000);
    check("rst_error",   error,   0);
    reset = 1'b0;
    @(negedge clk);

    // Clean loopback.
    expect_txn(16'hA53C, clean_plan(8'hA5), clean_plan(8'h3C));
    start_word(16'hA53C);
    wait_ready(500);

    // Parity error on MS byte; rx_word keeps the old value until the new done.
    p0 = clean_plan(8'h12);
    p0.perr = 1'b1;
    expect_txn(16'h1234, p0, clean_plan(8'h34));
    start_word(16'h1234);
    check("rx_word_held", rx_word, 16'hA53C);
    wait_ready(500);
    check("error_sticky_idle", error, 1);

    // Next start clears error; start held high with another word while busy is ignored.
    tc0 = tx_wr_count; dc0 = done_count;
    expect_txn(16'h5AC3, clean_plan(8'h5A), clean_plan(8'hC3));
    start_word(16'h5AC3);
    check("error_cleared_on_start", error, 0);
    word = 16'hFFFF; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("busy_done_seen", done, 1);
    @(negedge clk);
    start = 1'b0; word = 16'h0000;
    wait_ready(10);
    repeat (5) @(negedge clk);
    check("busy_tx_wr_count", tx_wr_count - tc0, 2);
    check("busy_done_count",  done_count - dc0,  1);

    // Randomized back-to-back traffic with corrupted bytes and error flags.
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      expect_txn(w, rand_plan(w[15:8]), rand_plan(w[7:0]));
      start_word(w);
    end
    wait_ready(500);
    check("sb_drained", sb.size(), 0);
    check("tx_exp_drained", tx_exp.size(), 0);

    // Reset while the MS byte is still being transmitted.
    dc0 = done_count;
    p0 = clean_plan(8'hC3);
    p0.d1 = 0; p0.busy_len = 20; p0.silent = 1'b1;
    plan_q.push_back(p0);
    tx_exp.push_back(8'hC3);
    start_word(16'hC33C);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready",   ready,   1);
    check("midrst_tx_en",   tx_en,   0);
    check("midrst_tx_wr",   tx_wr,   0);
    check("midrst_rx_en",   rx_en,   0);
    check("midrst_done",    done,    0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_rx_word", rx_word, 16'h0000);
    check("midrst_error",   error,   0);
    repeat (30) @(negedge clk);
    check("midrst_no_done", done_count - dc0, 0);
    expect_txn(16'h0F0F, clean_plan(8'h0F), clean_plan(8'h0F));
    start_word(16'h0F0F);
    wait_ready(500);
    check("after_rst_done", done_count - dc0, 1);

    // Receiver silent.
    tc0 = tx_wr_count; dc0 = done_count;
    p0 = clean_plan(8'h66); p0.silent = 1'b1;
    p1 = clean_plan(8'h99); p1.silent = 1'b1;
`ifdef SEQ_TIMEOUT_EN
    expect_txn(16'h6699, p0, p1);
    start_word(16'h6699);
    wait_ready(1000);
    check("timeout_done_count", done_count - dc0, 1);
    check("timeout_tx_wr_count", tx_wr_count - tc0, 2);
`else
    plan_q.push_back(p0);
    tx_exp.push_back(8'h66);
    start_word(16'h6699);
    repeat (10_000) @(negedge clk);
    check("silent_no_done", done_count - dc0, 0);
    check("silent_ready",   ready, 0);
    check("silent_rx_en",   rx_en, 1);
    check("silent_tx_wr_count", tx_wr_count - tc0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
